// File: rtl/exu_if.sv
// IDU -> EXU -> LSU bundle.
// Upstream decoded fields plus downstream LSU fields.
interface exu_if #(
  parameter int XLEN = 64,
  parameter int RIDW = 5
);
  logic            i_pre_valid;
  logic            o_pre_ready;
  logic            o_post_valid;
  logic            i_post_ready;
  logic [XLEN-1:0] i_idu_src1;
  logic [XLEN-1:0] i_idu_src2;
  logic [XLEN-1:0] i_idu_rs2;
  logic [3:0]      i_idu_exopt;
  logic            i_idu_word;
  logic [RIDW-1:0] i_idu_rdid;
  logic            i_idu_rdwen;
  logic [2:0]      i_idu_lsfunc3;
  logic            i_idu_lden;
  logic            i_idu_sten;
  logic [XLEN-1:0] s_idu_diffpc;
  logic [XLEN-1:0] o_exu_exres;
  logic [XLEN-1:0] o_exu_rs2;
  logic [RIDW-1:0] o_exu_rdid;
  logic            o_exu_rdwen;
  logic [2:0]      o_exu_lsfunc3;
  logic            o_exu_lden;
  logic            o_exu_sten;
  logic [XLEN-1:0] s_exu_diffpc;
  logic            o_exu_busy;

  modport master (
    output i_pre_valid, i_post_ready,
    output i_idu_src1, i_idu_src2,
    output i_idu_rs2, i_idu_exopt,
    output i_idu_word, i_idu_rdid,
    output i_idu_rdwen, i_idu_lsfunc3,
    output i_idu_lden, i_idu_sten,
    output s_idu_diffpc,
    input  o_pre_ready, o_post_valid,
    input  o_exu_exres, o_exu_rs2,
    input  o_exu_rdid, o_exu_rdwen,
    input  o_exu_lsfunc3, o_exu_lden,
    input  o_exu_sten, s_exu_diffpc,
    input  o_exu_busy
  );

  modport slave (
    input  i_pre_valid, i_post_ready,
    input  i_idu_src1, i_idu_src2,
    input  i_idu_rs2, i_idu_exopt,
    input  i_idu_word, i_idu_rdid,
    input  i_idu_rdwen, i_idu_lsfunc3,
    input  i_idu_lden, i_idu_sten,
    input  s_idu_diffpc,
    output o_pre_ready, o_post_valid,
    output o_exu_exres, o_exu_rs2,
    output o_exu_rdid, o_exu_rdwen,
    output o_exu_lsfunc3, o_exu_lden,
    output o_exu_sten, s_exu_diffpc,
    output o_exu_busy
  );
endinterface

// File: rtl/exu.sv
// Execute stage: 1-cycle ALU plus
// iterative shift-add mul / restoring div.
module exu #(
  parameter int XLEN = 64,
  parameter int RIDW = 5
) (
  input logic i_clk,
  input logic i_rst_n,
  exu_if.slave bus
);
  localparam int HW  = XLEN / 2;
  localparam int SW  = $clog2(XLEN);
  localparam int HSW = $clog2(HW);
  localparam int CW  = $clog2(XLEN + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_PASB = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REM  = 4'd14;

  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } st_t;

  function automatic logic [XLEN-1:0] sx(
    input logic [XLEN-1:0] v
  );
    return {{HW{v[HW-1]}}, v[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zx(
    input logic [XLEN-1:0] v
  );
    return {{HW{1'b0}}, v[HW-1:0]};
  endfunction

  logic            valid_r;
  logic [XLEN-1:0] src1_r, src2_r, rs2_r, pc_r;
  logic [3:0]      op_r;
  logic            word_r, rdwen_r;
  logic [RIDW-1:0] rdid_r;
  logic [2:0]      f3_r;
  logic            lden_r, sten_r;

  st_t             st;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] ra, rb, res_r;
  logic [XLEN:0]   acc;
  logic            neg_q, neg_r;

  logic mdu_r, post_valid, hs;
  logic pre_ready, cap;

  assign mdu_r      = op_r >= OP_MUL;
  assign post_valid = valid_r &
                      (!mdu_r | (st == DONE));
  assign hs         = post_valid & bus.i_post_ready;
  assign pre_ready  = !valid_r | hs;
  assign cap        = bus.i_pre_valid & pre_ready;

  logic            in_mdu, in_div, in_sgn, in_dz;
  logic            in_sa, in_sb, in_word;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a, in_b, mag_a, mag_b;
  logic [XLEN-1:0] dz_res;

  // MDU operand magnitudes and div-by-zero result
  always_comb begin
    in_op   = bus.i_idu_exopt;
    in_word = bus.i_idu_word;
    in_mdu  = in_op >= OP_MUL;
    in_div  = in_op >= OP_DIV;
    in_sgn  = (in_op == OP_DIV) |
              (in_op == OP_REM);
    in_a    = bus.i_idu_src1;
    in_b    = bus.i_idu_src2;
    if (in_word) begin
      in_a = in_sgn ? sx(bus.i_idu_src1)
                    : zx(bus.i_idu_src1);
      in_b = in_sgn ? sx(bus.i_idu_src2)
                    : zx(bus.i_idu_src2);
    end
    in_sa  = in_sgn & in_a[XLEN-1];
    in_sb  = in_sgn & in_b[XLEN-1];
    mag_a  = in_sa ? -in_a : in_a;
    mag_b  = in_sb ? -in_b : in_b;
    in_dz  = in_div & (in_b == '0);
    dz_res = in_word ? sx(bus.i_idu_src1)
                     : bus.i_idu_src1;
    if (in_op == OP_DIV || in_op == OP_DIVU)
      dz_res = '1;
  end

  logic [XLEN:0]   dv_t, dv_d;
  logic [XLEN-1:0] q_v, r_v, fin;

  // one restoring step and final sign fix-up
  always_comb begin
    dv_t = {acc[XLEN-1:0], rb[XLEN-1]};
    dv_d = dv_t - {1'b0, ra};
    q_v  = neg_q ? -rb : rb;
    r_v  = neg_r ? -acc[XLEN-1:0]
                 : acc[XLEN-1:0];
    if (op_r == OP_MUL)
      fin = acc[XLEN-1:0];
    else if (op_r == OP_DIV || op_r == OP_DIVU)
      fin = q_v;
    else
      fin = r_v;
    if (word_r)
      fin = sx(fin);
  end

  // instruction register, loads on upstream handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r <= 1'b0;
      src1_r  <= '0;
      src2_r  <= '0;
      rs2_r   <= '0;
      pc_r    <= '0;
      op_r    <= '0;
      word_r  <= 1'b0;
      rdid_r  <= '0;
      rdwen_r <= 1'b0;
      f3_r    <= '0;
      lden_r  <= 1'b0;
      sten_r  <= 1'b0;
    end else if (pre_ready) begin
      valid_r <= bus.i_pre_valid;
      if (cap) begin
        src1_r  <= bus.i_idu_src1;
        src2_r  <= bus.i_idu_src2;
        rs2_r   <= bus.i_idu_rs2;
        pc_r    <= bus.s_idu_diffpc;
        op_r    <= bus.i_idu_exopt;
        word_r  <= bus.i_idu_word;
        rdid_r  <= bus.i_idu_rdid;
        rdwen_r <= bus.i_idu_rdwen;
        f3_r    <= bus.i_idu_lsfunc3;
        lden_r  <= bus.i_idu_lden;
        sten_r  <= bus.i_idu_sten;
      end
    end
  end

  // MDU FSM: one mul/div bit per CALC cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st    <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_r <= '0;
    end else if (cap) begin
      if (in_mdu) begin
        cnt   <= in_word ? CW'(HW) : CW'(XLEN);
        neg_q <= in_sa ^ in_sb;
        neg_r <= in_sa;
        acc   <= '0;
        if (in_div) begin
          ra <= mag_b;
          rb <= in_word ? mag_a << HW : mag_a;
        end else begin
          ra <= bus.i_idu_src1;
          rb <= bus.i_idu_src2;
        end
        if (in_dz) begin
          st    <= DONE;
          res_r <= dz_res;
        end else begin
          st <= CALC;
        end
      end else begin
        st <= IDLE;
      end
    end else begin
      unique case (st)
        CALC: begin
          if (cnt == '0) begin
            st    <= DONE;
            res_r <= fin;
          end else begin
            cnt <= cnt - CW'(1);
            if (op_r == OP_MUL) begin
              if (rb[0])
                acc <= {1'b0,
                        acc[XLEN-1:0] + ra};
              ra <= ra << 1;
              rb <= rb >> 1;
            end else if (dv_d[XLEN]) begin
              acc <= dv_t;
              rb  <= {rb[XLEN-2:0], 1'b0};
            end else begin
              acc <= dv_d;
              rb  <= {rb[XLEN-2:0], 1'b1};
            end
          end
        end
        DONE: if (hs) st <= IDLE;
        default: ;
      endcase
    end
  end

  logic [XLEN-1:0] a_s, a_z, b_s, b_z;
  logic [XLEN-1:0] alu, alu_w;
  logic [SW-1:0]   sh;

  // single-cycle ALU on registered operands
  always_comb begin
    a_s = word_r ? sx(src1_r) : src1_r;
    a_z = word_r ? zx(src1_r) : src1_r;
    b_s = word_r ? sx(src2_r) : src2_r;
    b_z = word_r ? zx(src2_r) : src2_r;
    sh  = word_r ? SW'(src2_r[HSW-1:0])
                 : src2_r[SW-1:0];
    unique case (1'b1)
      op_r == OP_ADD:  alu = src1_r + src2_r;
      op_r == OP_SUB:  alu = src1_r - src2_r;
      op_r == OP_SLL:  alu = src1_r << sh;
      op_r == OP_SLT:
        alu = XLEN'($signed(a_s) < $signed(b_s));
      op_r == OP_SLTU: alu = XLEN'(a_z < b_z);
      op_r == OP_XOR:  alu = src1_r ^ src2_r;
      op_r == OP_SRL:  alu = a_z >> sh;
      op_r == OP_SRA:
        alu = $unsigned($signed(a_s) >>> sh);
      op_r == OP_OR:   alu = src1_r | src2_r;
      op_r == OP_AND:  alu = src1_r & src2_r;
      op_r == OP_PASB: alu = src2_r;
      default:         alu = '0;
    endcase
    alu_w = word_r ? sx(alu) : alu;
  end

  assign bus.o_pre_ready   = pre_ready;
  assign bus.o_post_valid  = post_valid;
  assign bus.o_exu_exres   = mdu_r ? res_r : alu_w;
  assign bus.o_exu_rs2     = rs2_r;
  assign bus.o_exu_rdid    = rdid_r;
  assign bus.o_exu_rdwen   = rdwen_r;
  assign bus.o_exu_lsfunc3 = f3_r;
  assign bus.o_exu_lden    = lden_r;
  assign bus.o_exu_sten    = sten_r;
  assign bus.s_exu_diffpc  = pc_r;
  assign bus.o_exu_busy    = valid_r & mdu_r &
                             (st != DONE);
endmodule

// File: tb/tb_exu.sv
// Bench for exu: directed vectors, a
// transaction-level model and per-cycle compare.
module tb_exu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   tag = 0;

  exu_if #(.XLEN(64), .RIDW(5)) bus();

  exu #(.XLEN(64), .RIDW(5)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = '1;

  typedef struct {
    logic [63:0] res, rs2, pc;
    logic [4:0]  rdid;
    logic        rdwen, ld, st;
    logic [2:0]  f3;
    int          cap, due;
    bit          mdu;
  } exp_t;

  exp_t q[$];

  task automatic chk(string n, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               n, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] m64(
    logic [3:0] op, logic [63:0] a, logic [63:0] b);
    longint sa, sb;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[5:0];
      3: return {63'b0, sa < sb};
      4: return {63'b0, a < b};
      5: return a ^ b;
      6: return a >> b[5:0];
      7: return sa >>> b[5:0];
      8: return a | b;
      9: return a & b;
      10: return b;
      11: return a * b;
      12: begin
        if (b == 0) return ONES;
        if (a == MIN && b == ONES) return MIN;
        return sa / sb;
      end
      13: return (b == 0) ? ONES : a / b;
      14: begin
        if (b == 0) return a;
        if (a == MIN && b == ONES) return 0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] m32(
    logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return {31'b0, sa < sb};
      4: return {31'b0, a < b};
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return sa >>> b[4:0];
      8: return a | b;
      9: return a & b;
      10: return b;
      11: return a * b;
      12: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1)
          return 32'h8000_0000;
        return sa / sb;
      end
      13: return (b == 0) ? '1 : a / b;
      14: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return 0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [63:0] model(
    logic [3:0] op, logic w,
    logic [63:0] a, logic [63:0] b);
    logic [31:0] r;
    if (!w) return m64(op, a, b);
    r = m32(op, a[31:0], b[31:0]);
    return {{32{r[31]}}, r};
  endfunction

  // per-cycle compare against the transaction model
  always @(negedge clk) begin : cmp
    bit hc, ev, ep, eb, dz;
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      hc = q.size() > 0 && cyc >= q[0].cap;
      ev = hc && cyc >= q[0].due;
      eb = hc && q[0].mdu && cyc < q[0].due;
      ep = !hc || (ev && bus.i_post_ready);
      chk("post_valid", 64'(bus.o_post_valid), 64'(ev));
      chk("pre_ready", 64'(bus.o_pre_ready), 64'(ep));
      chk("busy", 64'(bus.o_exu_busy), 64'(eb));
      if (ev) begin
        chk("exres", bus.o_exu_exres, q[0].res);
        chk("rs2", bus.o_exu_rs2, q[0].rs2);
        chk("diffpc", bus.s_exu_diffpc, q[0].pc);
        chk("rdid", 64'(bus.o_exu_rdid),
            64'(q[0].rdid));
        chk("ctl",
            {59'b0, bus.o_exu_rdwen, bus.o_exu_lden,
             bus.o_exu_sten, bus.o_exu_lsfunc3[1:0]},
            {59'b0, q[0].rdwen, q[0].ld, q[0].st,
             q[0].f3[1:0]});
        chk("lsf3b2", 64'(bus.o_exu_lsfunc3[2]),
            64'(q[0].f3[2]));
        if (bus.i_post_ready) void'(q.pop_front());
      end
      if (bus.i_pre_valid && ep) begin
        e.res  = model(bus.i_idu_exopt, bus.i_idu_word,
                       bus.i_idu_src1, bus.i_idu_src2);
        e.rs2  = bus.i_idu_rs2;
        e.pc   = bus.s_idu_diffpc;
        e.rdid = bus.i_idu_rdid;
        e.rdwen = bus.i_idu_rdwen;
        e.ld   = bus.i_idu_lden;
        e.st   = bus.i_idu_sten;
        e.f3   = bus.i_idu_lsfunc3;
        e.mdu  = bus.i_idu_exopt >= 11;
        dz = bus.i_idu_exopt >= 12 &&
             (bus.i_idu_word ? bus.i_idu_src2[31:0] == 0
                             : bus.i_idu_src2 == 0);
        e.cap = cyc + 1;
        e.due = e.cap;
        if (e.mdu && !dz)
          e.due = e.cap + (bus.i_idu_word ? 33 : 65);
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [3:0] op, logic w,
                       logic [63:0] a, logic [63:0] b,
                       logic ld, logic st,
                       logic [2:0] f3);
    int n;
    n = 0;
    tag++;
    bus.i_idu_exopt   = op;
    bus.i_idu_word    = w;
    bus.i_idu_src1    = a;
    bus.i_idu_src2    = b;
    bus.i_idu_rs2     = {32'hA5A5_0000, 32'(tag)};
    bus.i_idu_rdid    = 5'(tag);
    bus.i_idu_rdwen   = tag[0];
    bus.i_idu_lden    = ld;
    bus.i_idu_sten    = st;
    bus.i_idu_lsfunc3 = f3;
    bus.s_idu_diffpc  = 64'h8000_0000 + 64'(tag * 4);
    bus.i_pre_valid   = 1'b1;
    @(negedge clk);
    while (!bus.o_pre_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("issue_timeout", 0, 1);
    step();
    bus.i_pre_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.o_post_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("valid_timeout", 0, 1);
  endtask

  task automatic run1(string nm, logic [3:0] op,
                      logic w, logic [63:0] a,
                      logic [63:0] b, logic [63:0] r,
                      int lat);
    int n;
    issue(op, w, a, b, 1'b0, 1'b0, 3'd0);
    wait_valid(n);
    chk(nm, bus.o_exu_exres, r);
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    step();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_valid"}, 64'(bus.o_post_valid), 0);
    chk({nm, "_exres"}, bus.o_exu_exres, 0);
    chk({nm, "_rs2"}, bus.o_exu_rs2, 0);
    chk({nm, "_pc"}, bus.s_exu_diffpc, 0);
    chk({nm, "_rdid"}, 64'(bus.o_exu_rdid), 0);
    chk({nm, "_busy"}, 64'(bus.o_exu_busy), 0);
  endtask

  initial begin : stim
    int n;
    bus.i_pre_valid   = 1'b0;
    bus.i_post_ready  = 1'b1;
    bus.i_idu_exopt   = '0;
    bus.i_idu_word    = 1'b0;
    bus.i_idu_src1    = '0;
    bus.i_idu_src2    = '0;
    bus.i_idu_rs2     = '0;
    bus.i_idu_rdid    = '0;
    bus.i_idu_rdwen   = 1'b0;
    bus.i_idu_lden    = 1'b0;
    bus.i_idu_sten    = 1'b0;
    bus.i_idu_lsfunc3 = '0;
    bus.s_idu_diffpc  = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    step();
    rst_n = 1'b1;
    step();

    run1("add", 0, 0, 5, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    issue(0, 0, 5, -64'sd7, 0, 0, 0);
    issue(1, 0, 64'd100, 64'd1, 0, 0, 0);
    issue(5, 0, 64'hFF, 64'h0F, 0, 0, 0);
    repeat (3) step();

    run1("sub", 1, 0, 5, 7, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run1("sll", 2, 0, 1, 63, MIN, 0);
    run1("slt", 3, 0, ONES, 1, 1, 0);
    run1("sltu", 4, 0, ONES, 1, 0, 0);
    run1("xor", 5, 0, 64'hF0F0, 64'hFF00, 64'h0FF0, 0);
    run1("srl", 6, 0, MIN, 63, 1, 0);
    run1("sra", 7, 0, MIN, 4, 64'hF800_0000_0000_0000, 0);
    run1("or", 8, 0, 64'hF0, 64'h0F, 64'hFF, 0);
    run1("and", 9, 0, 64'hF0, 64'h3C, 64'h30, 0);
    run1("passb", 10, 0, 64'd9, 64'h1234, 64'h1234, 0);
    run1("addw", 0, 1, 64'h7FFF_FFFF, 1,
         64'hFFFF_FFFF_8000_0000, 0);
    run1("sraw", 7, 1, 64'h8000_0000, 4,
         64'hFFFF_FFFF_F800_0000, 0);
    run1("sllw", 2, 1, 1, 31, 64'hFFFF_FFFF_8000_0000, 0);
    run1("srlw", 6, 1, 64'hFFFF_FFFF_8000_0000, 4,
         64'h0800_0000, 0);

    issue(0, 0, 64'h1000, 64'h18, 1, 0, 3'd3);
    issue(0, 0, 64'h2000, -64'sd8, 0, 1, 3'd2);
    repeat (2) step();

    run1("mul", 11, 0, -64'sd3, 7, -64'sd21, 65);
    run1("div", 12, 0, -64'sd20, 3, -64'sd6, 65);
    run1("rem", 14, 0, -64'sd20, 3, -64'sd2, 65);
    run1("divw", 12, 1, -64'sd20, 3, -64'sd6, 33);
    run1("remw", 14, 1, -64'sd20, 3, -64'sd2, 33);
    run1("div_neg", 12, 0, 7, -64'sd2, -64'sd3, 65);
    run1("rem_neg", 14, 0, 7, -64'sd2, 1, 65);
    run1("divu", 13, 0, 100, 7, 14, 65);
    run1("remu", 15, 0, 100, 7, 2, 65);
    run1("divu_big", 13, 0, ONES, 3,
         64'h5555_5555_5555_5555, 65);
    run1("divu_z", 13, 0, 123, 0, ONES, 0);
    run1("remu_z", 15, 0, 123, 0, 123, 0);
    run1("div_z", 12, 0, -64'sd5, 0, ONES, 0);
    run1("divuw_z", 13, 1, 64'h77, 64'h1_0000_0000,
         ONES, 0);
    run1("div_ovf", 12, 0, MIN, ONES, MIN, 65);
    run1("rem_ovf", 14, 0, MIN, ONES, 0, 65);
    run1("divw_ovf", 12, 1, 64'h8000_0000, ONES,
         64'hFFFF_FFFF_8000_0000, 33);

    bus.i_post_ready = 1'b0;
    issue(11, 1, 64'h7FFF_FFFF, 2, 0, 0, 0);
    wait_valid(n);
    chk("mulw_lat", 64'(n), 33);
    for (int i = 0; i < 5; i++) begin
      chk("mulw_hold", bus.o_exu_exres,
          64'hFFFF_FFFF_FFFF_FFFE);
      chk("mulw_preq", 64'(bus.o_pre_ready), 0);
      @(negedge clk);
    end
    step();
    bus.i_post_ready = 1'b1;
    step();
    step();

    issue(11, 0, 64'h1_0000_0001, 64'h10, 0, 0, 0);
    issue(12, 0, 64'd1000, 64'd10, 0, 0, 0);
    wait_valid(n);
    chk("b2b_div", bus.o_exu_exres, 100);
    chk("b2b_lat", 64'(n), 65);
    step();

    issue(12, 0, -64'sd20, 3, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.o_post_valid) n++;
    end
    chk("no_result_after_rst", 64'(n), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end
endmodule
